// File: rtl/rv32_bram_sdp.sv
// ----------------------------------------------------------------------------
// rv32_bram_sdp
//   Simple-dual-port block RAM used as backing store for the RV32 register
//   file, scratchpad and instruction memory. It uses a single clock and has:
//     - per-lane write enables (NUM_LANES = DATA_WIDTH / LANE_WIDTH)
//     - write-first forwarding when a read and a write hit the same address
//     - an optional extra output register (OUT_REG=1 gives read latency 2)
//     - an rvalid strobe marking each new rdata
//     - a clear sequencer that zeroes every entry after reset
//
//   Optional feature macro: BRAM_PARITY_EN
//     When defined, each lane stores one even-parity bit and the module has a
//     parity_err output. parity_err is asserted together with rvalid when any
//     stored lane fails its parity check.
//
//   Ports
//     clk        : sole clock; all logic runs on the rising edge
//     rst        : synchronous active-high reset
//     init_busy  : high while the clear sequencer runs
//     wen        : write request
//     wbe        : per-lane write enable, qualified by wen
//     waddr      : write address
//     wdata      : write data
//     ren        : read request
//     raddr      : read address
//     rdata      : read data; holds its value between reads
//     rvalid     : one-cycle strobe marking new rdata
//     parity_err : lane parity mismatch (present only with BRAM_PARITY_EN)
// ----------------------------------------------------------------------------
module rv32_bram_sdp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int LANE_WIDTH     = 8,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             init_busy,
    input  logic                             wen,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wbe,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic                             ren,
    input  logic [ADDR_WIDTH-1:0]            raddr,
    output logic [DATA_WIDTH-1:0]            rdata,
`ifdef BRAM_PARITY_EN
    output logic                             rvalid,
    output logic                             parity_err
`else
    output logic                             rvalid
`endif
);

    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    run;

    // ------------------------------------------------------------------
    // Clear / run sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_CLEAR) begin
            ptr_d = ptr_q + 1'b1;
            // The last entry is written on this edge, so leave CLEAR on the
            // same edge. The pointer wraps back to 0.
            if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        init_busy = (state_q == ST_CLEAR);
        run       = (state_q == ST_RUN);
    end

    // ------------------------------------------------------------------
    // Shared write/read qualifiers
    // ------------------------------------------------------------------
    logic                  clr_we;
    logic                  user_we;
    logic                  rd_en;
    logic                  same_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;

    // The clear writes take over the write port. User traffic is ignored
    // until the sequencer reaches RUN.
    assign clr_we    = init_busy & ~rst;
    assign user_we   = run & wen & ~rst;
    assign rd_en     = run & ren & ~rst;
    assign same_addr = (waddr == raddr);
    assign wr_addr   = clr_we ? ptr_q : waddr;

    logic [DATA_WIDTH-1:0] s1_data;
    logic [NUM_LANES-1:0]  s1_perr;
    logic                  s1_valid_q;

    // ------------------------------------------------------------------
    // One RAM per lane. Each lane has its own registered read port, and
    // write-first forwarding is done per lane.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [LANE_WIDTH-1:0] mem_q [DEPTH];
            logic [LANE_WIDTH-1:0] wr_lane;
            logic [LANE_WIDTH-1:0] wd_lane;
            logic                  lane_we;
            logic                  fwd;
            logic [LANE_WIDTH-1:0] rd_q;

            assign wd_lane = wdata[gi*LANE_WIDTH +: LANE_WIDTH];
            assign wr_lane = clr_we ? '0 : wd_lane;
            assign lane_we = clr_we | (user_we & wbe[gi]);
            assign fwd     = user_we & wbe[gi] & same_addr;

            always_ff @(posedge clk) begin
                if (lane_we) begin
                    mem_q[wr_addr] <= wr_lane;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= fwd ? wd_lane : mem_q[raddr];
                end
            end

            assign s1_data[gi*LANE_WIDTH +: LANE_WIDTH] = rd_q;

`ifdef BRAM_PARITY_EN
            logic par_q [DEPTH];
            logic perr_q;

            // A cleared lane is all zeros, so its even parity is also 0.
            always_ff @(posedge clk) begin
                if (lane_we) begin
                    par_q[wr_addr] <= ^wr_lane;
                end
            end

            // Forwarded data never touched the array, so it is reported clean.
            always_ff @(posedge clk) begin
                if (rst) begin
                    perr_q <= 1'b0;
                end else if (rd_en) begin
                    perr_q <= fwd ? 1'b0 : ((^mem_q[raddr]) != par_q[raddr]);
                end
            end

            assign s1_perr[gi] = perr_q;
`else
            assign s1_perr[gi] = 1'b0;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_en;
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic perr_out;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  rvalid_q;
            logic                  perr_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                    perr_q   <= 1'b0;
                end else begin
                    rvalid_q <= s1_valid_q;
                    perr_q   <= s1_valid_q & (|s1_perr);
                    if (s1_valid_q) begin
                        rdata_q <= s1_data;
                    end
                end
            end

            assign rdata    = rdata_q;
            assign rvalid   = rvalid_q;
            assign perr_out = perr_q;
        end else begin : g_noreg
            assign rdata    = s1_data;
            assign rvalid   = s1_valid_q;
            assign perr_out = s1_valid_q & (|s1_perr);
        end
    endgenerate

`ifdef BRAM_PARITY_EN
    assign parity_err = perr_out;
`else
    logic unused_perr;
    assign unused_perr = perr_out;
`endif

endmodule

// File: tb/tb_rv32_bram_sdp.sv
module tb_rv32_bram_sdp;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wen, ren;
    logic [3:0]  wbe, waddr, raddr;
    logic [31:0] wdata;
    logic        busy0, busy1, rv0, rv1;
    logic [31:0] rd0, rd1;
`ifdef BRAM_PARITY_EN
    logic        pe0, pe1;
`endif

    int errors = 0;
    int checks = 0;
    int pulses0 = 0;
    int pulses1 = 0;
    logic chk_en = 1'b0;
    logic skip   = 1'b0;

    rv32_bram_sdp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .LANE_WIDTH(8),
                    .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .rst(rst), .init_busy(busy0), .wen(wen), .wbe(wbe),
        .waddr(waddr), .wdata(wdata), .ren(ren), .raddr(raddr),
        .rdata(rd0),
`ifdef BRAM_PARITY_EN
        .rvalid(rv0), .parity_err(pe0)
`else
        .rvalid(rv0)
`endif
    );

    rv32_bram_sdp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .LANE_WIDTH(8),
                    .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst(rst), .init_busy(busy1), .wen(wen), .wbe(wbe),
        .waddr(waddr), .wdata(wdata), .ren(ren), .raddr(raddr),
        .rdata(rd1),
`ifdef BRAM_PARITY_EN
        .rvalid(rv1), .parity_err(pe1)
`else
        .rvalid(rv1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference: a word array, a countdown for the clear
    // period, and the read results delayed by one or two edges.
    // ------------------------------------------------------------------
    logic [31:0] m_mem [DEPTH];
    int          busy_left = 0;
    logic        a_v = 1'b0, b_v = 1'b0;
    logic [31:0] a_d = '0, e0 = '0, e1 = '0;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int l = 0; l < 4; l++) begin
            if (be[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            busy_left <= DEPTH;
            a_v <= 1'b0;
            b_v <= 1'b0;
            e0  <= '0;
            e1  <= '0;
        end else begin
            b_v <= a_v;
            if (a_v) e1 <= a_d;
            if (busy_left > 0) begin
                busy_left <= busy_left - 1;
                a_v <= 1'b0;
                if (busy_left == 1) begin
                    for (int k = 0; k < DEPTH; k++) m_mem[k] <= '0;
                end
            end else begin
                a_v <= ren;
                if (ren) begin
                    if (wen && waddr == raddr) begin
                        a_d <= merge(m_mem[raddr], wdata, wbe);
                        e0  <= merge(m_mem[raddr], wdata, wbe);
                    end else begin
                        a_d <= m_mem[raddr];
                        e0  <= m_mem[raddr];
                    end
                end
                if (wen) m_mem[waddr] <= merge(m_mem[waddr], wdata, wbe);
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (chk_en && !skip) begin
            check("busy0",  {31'd0, busy0}, {31'd0, busy_left != 0});
            check("busy1",  {31'd0, busy1}, {31'd0, busy_left != 0});
            check("rvalid0", {31'd0, rv0}, {31'd0, a_v});
            check("rvalid1", {31'd0, rv1}, {31'd0, b_v});
            check("rdata0", rd0, e0);
            check("rdata1", rd1, e1);
`ifdef BRAM_PARITY_EN
            check("perr0", {31'd0, pe0}, 32'd0);
            check("perr1", {31'd0, pe1}, 32'd0);
`endif
        end
    end

    always @(negedge clk) begin
        if (rv0) pulses0++;
        if (rv1) pulses1++;
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wen = 1'b1; waddr = a; wdata = d; wbe = be;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(name, n, 16);
    endtask

    int p0, p1;

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0; wbe = '0;
        waddr = '0; raddr = '0; wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        count_busy("clear_cycles");

        // All entries read back as zero after the clear
        p0 = pulses0; p1 = pulses1;
        for (int i = 0; i < DEPTH; i++) begin
            ren = 1'b1; raddr = 4'(i);
            @(negedge clk);
        end
        ren = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("clear_reads0", pulses0 - p0, 16);
        check("clear_reads1", pulses1 - p1, 16);
        check("clear_rdata0", rd0, 32'h0);

        // Byte-lane write, then the latency of a single read
        wr(4'h5, 32'hDEADBEEF, 4'b1111);
        wr(4'h5, 32'h00000011, 4'b0001);
        ren = 1'b1; raddr = 4'h5;
        @(negedge clk);
        ren = 1'b0;
        check("lat1_rv0", {31'd0, rv0}, 32'd1);
        check("lat1_rv1", {31'd0, rv1}, 32'd0);
        check("lane_rd0", rd0, 32'hDEADBE11);
        @(negedge clk);
        check("lat2_rv0", {31'd0, rv0}, 32'd0);
        check("lat2_rv1", {31'd0, rv1}, 32'd1);
        check("lane_rd1", rd1, 32'hDEADBE11);
        check("hold_rd0", rd0, 32'hDEADBE11);

        // Four back-to-back reads
        for (int i = 0; i < 4; i++) wr(4'(8 + i), 32'h1000_0000 * (i + 1) + 32'(i), 4'hF);
        p0 = pulses0; p1 = pulses1;
        for (int i = 0; i < 4; i++) begin
            ren = 1'b1; raddr = 4'(8 + i);
            @(negedge clk);
        end
        ren = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b2b_pulses0", pulses0 - p0, 4);
        check("b2b_pulses1", pulses1 - p1, 4);
        check("b2b_last1", rd1, 32'h4000_0003);

        // Read during write to the same address
        wr(4'h7, 32'h11223344, 4'hF);
        wen = 1'b1; waddr = 4'h7; wdata = 32'hAABBCCDD; wbe = 4'b1010;
        ren = 1'b1; raddr = 4'h7;
        @(negedge clk);
        wen = 1'b0; ren = 1'b0;
        check("rdw_rd0", rd0, 32'hAA22CC44);
        @(negedge clk);
        check("rdw_rd1", rd1, 32'hAA22CC44);
        ren = 1'b1; raddr = 4'h7;
        @(negedge clk);
        ren = 1'b0;
        check("rdw_again0", rd0, 32'hAA22CC44);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            wen   = 1'($urandom);
            wbe   = 4'($urandom);
            waddr = 4'($urandom);
            wdata = $urandom;
            ren   = 1'($urandom);
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; wen = 1'b0; ren = 1'b0;
        repeat (20) @(negedge clk);

        // Reset in the middle of the clear sequence
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (9) @(negedge clk);
        check("midclear_busy", {31'd0, busy0}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy("restart_cycles");

        // Reset with a read in flight drops the OUT_REG=1 result
        wr(4'h5, 32'hCAFEF00D, 4'hF);
        ren = 1'b1; raddr = 4'h5;
        @(negedge clk);
        ren = 1'b0; rst = 1'b1;
        p1 = pulses1;
        @(negedge clk);
        rst = 1'b0;
        check("inflight_rv1", {31'd0, rv1}, 32'd0);
        @(negedge clk);
        check("inflight_drop", pulses1 - p1, 0);
        repeat (20) @(negedge clk);

`ifdef BRAM_PARITY_EN
        wr(4'h3, 32'h0000_0055, 4'hF);
        wr(4'h4, 32'h1234_5678, 4'hF);
        skip = 1'b1;
        u_dut0.g_lane[0].mem_q[3][0] = ~u_dut0.g_lane[0].mem_q[3][0];
        u_dut1.g_lane[0].mem_q[3][0] = ~u_dut1.g_lane[0].mem_q[3][0];
        ren = 1'b1; raddr = 4'h3;
        @(negedge clk);
        ren = 1'b0;
        check("perr_bad0", {31'd0, pe0}, 32'd1);
        @(negedge clk);
        check("perr_bad1", {31'd0, pe1}, 32'd1);
        ren = 1'b1; raddr = 4'h4;
        @(negedge clk);
        ren = 1'b0;
        check("perr_clean0", {31'd0, pe0}, 32'd0);
        @(negedge clk);
        check("perr_clean1", {31'd0, pe1}, 32'd0);
        wr(4'h3, 32'h0000_0055, 4'hF);
        ren = 1'b1; raddr = 4'h3;
        @(negedge clk);
        ren = 1'b0;
        @(negedge clk);
        @(negedge clk);
        skip = 1'b0;
        repeat (4) @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
